// File: rtl/bmc_pkg.sv
// Shared types and interval classification for the biphase-mark receiver.
package bmc_pkg;

  typedef enum logic [1:0] {HUNT, BIT_START, MID_ONE} rx_state_t;
  typedef enum logic [1:0] {IV_SHORT, IV_LONG, IV_BAD} ival_t;

  // SHORT and LONG windows never overlap because TOL < HALF_CYCLES/2.
  function automatic ival_t classify(input int unsigned cnt,
                                     input int unsigned half_cycles,
                                     input int unsigned tol);
    if (cnt >= half_cycles - tol && cnt <= half_cycles + tol) return IV_SHORT;
    if (cnt >= 2 * half_cycles - tol && cnt <= 2 * half_cycles + tol) return IV_LONG;
    return IV_BAD;
  endfunction

endpackage

// File: rtl/bmc_receiver_if.sv
// Line input and decoded-bit/status outputs of the BMC receiver.
interface bmc_receiver_if;
  logic din;
  logic dout;
  logic dout_valid;
  logic locked;
  logic err;

  modport master (output din, input dout, input dout_valid, input locked, input err);
  modport slave  (input din, output dout, output dout_valid, output locked, output err);
endinterface

// File: rtl/bmc_sync_edge.sv
// Two-flop synchroniser plus history flop; flags any level change of the synchronised input.
module bmc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 ^ s3;

endmodule

// File: rtl/bmc_receiver.sv
// Biphase-mark line decoder: measures edge spacing and recovers bits, lock and error status.
module bmc_receiver
  import bmc_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 8,
  parameter int unsigned TOL         = 2
) (
  input  logic           clk,
  input  logic           rst,
  bmc_receiver_if.slave  bus
);

  localparam int unsigned LongMax = 2 * HALF_CYCLES + TOL;
  localparam int unsigned CntW    = $clog2(LongMax + 2);
  localparam logic [CntW-1:0] CntSat = CntW'(LongMax + 1);

  logic            edge_pulse;
  logic [CntW-1:0] cnt;
  ival_t           ival;
  rx_state_t       state;

  bmc_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .din        (bus.din),
    .edge_pulse (edge_pulse)
  );

  // cnt holds the length of the interval that an edge in this cycle closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (edge_pulse) begin
      cnt <= CntW'(1);
    end else if (cnt != CntSat) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb ival = classify(32'(cnt), HALF_CYCLES, TOL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= HUNT;
      bus.dout       <= 1'b0;
      bus.dout_valid <= 1'b0;
      bus.locked     <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.dout_valid <= 1'b0;
      bus.err        <= 1'b0;
      if (edge_pulse) begin
        unique case (state)
          HUNT: begin
            // Only a full-bit interval is unambiguous: it can only be a 0.
            if (ival == IV_LONG) begin
              bus.dout       <= 1'b0;
              bus.dout_valid <= 1'b1;
              bus.locked     <= 1'b1;
              state          <= BIT_START;
            end
          end
          BIT_START: begin
            unique case (ival)
              IV_LONG: begin
                bus.dout       <= 1'b0;
                bus.dout_valid <= 1'b1;
              end
              IV_SHORT: state <= MID_ONE;
              default: begin
                bus.err    <= 1'b1;
                bus.locked <= 1'b0;
                state      <= HUNT;
              end
            endcase
          end
          MID_ONE: begin
            if (ival == IV_SHORT) begin
              bus.dout       <= 1'b1;
              bus.dout_valid <= 1'b1;
              state          <= BIT_START;
            end else begin
              bus.err    <= 1'b1;
              bus.locked <= 1'b0;
              state      <= HUNT;
            end
          end
          default: begin
            bus.locked <= 1'b0;
            state      <= HUNT;
          end
        endcase
      end else if (state != HUNT && cnt == CntSat) begin
        // Line went quiet for longer than any legal interval.
        bus.err    <= 1'b1;
        bus.locked <= 1'b0;
        state      <= HUNT;
      end
    end
  end

endmodule
